imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words and writes
// them to the instruction memory while stalling the CPU; passes the CPU PC through when idle.
module imem_loader #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [31:0]       cpu_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StFinish} state_e;

  state_e          state_q;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] word_ptr_q;
  logic [1:0]      byte_idx_q;
  logic [TmoW-1:0] tmo_q;
  logic [31:0]     wdata_q;
  logic            err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_ptr_q <= '0;
      byte_idx_q <= '0;
      tmo_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            word_ptr_q <= '0;
            byte_idx_q <= '0;
            tmo_q      <= '0;
            if (len_words > MaxLen) begin
              len_q   <= MaxLen;
              err_q   <= 1'b1;
              state_q <= StRecv;
            end else begin
              len_q   <= len_words;
              err_q   <= 1'b0;
              state_q <= (len_words == '0) ? StFinish : StRecv;
            end
          end
        end
        StRecv: begin
          if (byte_valid) begin
            tmo_q <= '0;
            unique case (byte_idx_q)
              2'd0: wdata_q[31:24] <= byte_data;
              2'd1: wdata_q[23:16] <= byte_data;
              2'd2: wdata_q[15:8]  <= byte_data;
              2'd3: wdata_q[7:0]   <= byte_data;
              default: ;
            endcase
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) state_q <= StWrite;
          end else if (tmo_q == TmoLast) begin
            // Stalled stream: drop the partial word and flag the abort.
            err_q   <= 1'b1;
            state_q <= StFinish;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StWrite: begin
          word_ptr_q <= word_ptr_q + 1'b1;
          state_q    <= (word_ptr_q + 1'b1 == len_q) ? StFinish : StRecv;
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Outputs are state decodes; reset masks them so a write in flight is suppressed at once.
  always_comb begin
    busy       = (state_q != StIdle) && !reset;
    cpu_stall  = busy;
    byte_ready = (state_q == StRecv) && !reset;
    mem_we     = (state_q == StWrite) && !reset;
    done       = (state_q == StFinish) && !reset;
    err        = err_q && !reset;
    mem_wdata  = wdata_q;
    mem_addr   = ((state_q == StIdle) || reset) ? cpu_pc[ADDR_W+1:2]
                                                 : word_ptr_q[ADDR_W-1:0];
  end

  logic unused_pc;
  assign unused_pc = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as bytes are driven and
// matched against mem_we cycles by a monitor.
module tb_imem_loader;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [AW:0]   len_words;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [31:0]   cpu_pc;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we, cpu_stall, busy, done, err;

  imem_loader #(.ADDR_W(AW), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len_words (len_words),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .cpu_pc    (cpu_pc),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_stall (cpu_stall),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  we_cyc[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  wr_cnt = 0;
  int  acc_since = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples settled values just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (start && !busy && !reset) acc_since = 0;
    if (byte_valid && byte_ready) acc_since++;
    if (done) done_cnt++;
    if (mem_we) begin
      wr_cnt++;
      we_cyc.push_back(cyc);
      check("we_after4", acc_since, 4);
      acc_since = 0;
      if (exp_q.size() == 0) begin
        check("we_unexp", {31'b0, mem_we}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {22'b0, mem_addr}, {22'b0, e.addr});
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) check("ready_to", {31'b0, byte_ready}, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8], gap);
  endtask

  task automatic go(input logic [AW:0] len);
    start     = 1'b1;
    len_words = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_to", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int d0, rec0, w0;
    reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_data = 8'h55;
    len_words = 11'd2; cpu_pc = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {31'b0, byte_ready}, 0);
    check("rst_we",    {31'b0, mem_we}, 0);
    check("rst_stall", {31'b0, cpu_stall}, 0);
    check("rst_busy",  {31'b0, busy}, 0);
    check("rst_done",  {31'b0, done}, 0);
    check("rst_err",   {31'b0, err}, 0);
    check("rst_addr",  {22'b0, mem_addr}, 32'h10);
    start = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 0);

    // IDLE passthrough
    cpu_pc = 32'h0000_0FFC;
    #1;
    check("pass_addr",  {22'b0, mem_addr}, 32'h3FF);
    check("pass_we",    {31'b0, mem_we}, 0);
    check("pass_stall", {31'b0, cpu_stall}, 0);
    @(negedge clk);

    // Nominal two-word load
    exp_q.push_back('{addr: 0, data: 32'h12345678});
    exp_q.push_back('{addr: 1, data: 32'h9ABCDEF0});
    d0 = done_cnt;
    we_cyc.delete();
    go(11'd2);
    rec0 = cyc;
    check("nom_busy",  {31'b0, busy}, 1);
    check("nom_stall", {31'b0, cpu_stall}, 1);
    check("nom_ready", {31'b0, byte_ready}, 1);
    check("nom_addr",  {22'b0, mem_addr}, 0);
    send_word(32'h12345678, 0);
    send_word(32'h9ABCDEF0, 0);
    wait_idle(20);
    check("nom_done", done_cnt - d0, 1);
    check("nom_err",  {31'b0, err}, 0);
    check("nom_nwr",  we_cyc.size(), 2);
    if (we_cyc.size() == 2) begin
      check("nom_t0", we_cyc[0] - rec0 + 1, 5);
      check("nom_t1", we_cyc[1] - rec0 + 1, 10);
    end
    check("nom_q", exp_q.size(), 0);

    // Backpressure with a start pulse while busy
    exp_q.push_back('{addr: 0, data: 32'hA1B2C3D4});
    d0 = done_cnt; w0 = wr_cnt;
    go(11'd1);
    send(8'hA1, 1);
    start = 1'b1; len_words = 11'd5;
    send(8'hB2, 1);
    start = 1'b0;
    send(8'hC3, 1);
    send(8'hD4, 0);
    wait_idle(20);
    check("bp_done", done_cnt - d0, 1);
    check("bp_nwr",  wr_cnt - w0, 1);
    check("bp_q",    exp_q.size(), 0);

    // Zero length
    d0 = done_cnt; w0 = wr_cnt;
    go(11'd0);
    check("zero_done", {31'b0, done}, 1);
    @(negedge clk);
    check("zero_busy", {31'b0, busy}, 0);
    check("zero_cnt",  done_cnt - d0, 1);
    check("zero_nwr",  wr_cnt - w0, 0);

    // Timeout after two bytes
    d0 = done_cnt; w0 = wr_cnt;
    go(11'd2);
    send(8'h11, 0);
    send(8'h22, 0);
    wait_idle(100);
    check("tmo_err",  {31'b0, err}, 1);
    check("tmo_done", done_cnt - d0, 1);
    check("tmo_nwr",  wr_cnt - w0, 0);
    repeat (3) @(negedge clk);
    check("tmo_sticky", {31'b0, err}, 1);

    // Reset during WRITE
    d0 = done_cnt; w0 = wr_cnt;
    go(11'd1);
    check("rw_errclr", {31'b0, err}, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    check("rw_state", {31'b0, mem_we}, 1);
    reset = 1'b1;
    #1;
    check("rw_we", {31'b0, mem_we}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rw_busy",  {31'b0, busy}, 0);
    check("rw_stall", {31'b0, cpu_stall}, 0);
    check("rw_we2",   {31'b0, mem_we}, 0);
    @(negedge clk);
    check("rw_done", done_cnt - d0, 0);
    check("rw_nwr",  wr_cnt - w0, 0);

    // Oversized length clamps to full memory
    d0 = done_cnt; w0 = wr_cnt;
    go(11'd1025);
    check("big_err", {31'b0, err}, 1);
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = 32'hC0DE_0000 | i;
      exp_q.push_back('{addr: i[AW-1:0], data: w});
      send_word(w, 0);
    end
    wait_idle(20);
    check("big_nwr",  wr_cnt - w0, 1024);
    check("big_done", done_cnt - d0, 1);
    check("big_err2", {31'b0, err}, 1);
    check("big_q",    exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
